// File: rtl/secded_pkg.sv
// Shared SECDED bit-layout helpers and status encoding, used by both the encoder and the decoder.
package secded_pkg;

  typedef enum logic [1:0] {
    CLEAN  = 2'd0,
    SINGLE = 2'd1,
    DOUBLE = 2'd2
  } status_e;

  // Smallest p with 2^p >= data_w + p + 1.
  function automatic int calc_p(input int data_w);
    int p;
    p = 7;
    for (int k = 7; k >= 1; k--) begin
      if ((1 << k) >= data_w + k + 1) p = k;
    end
    return p;
  endfunction

  function automatic bit is_pow2(input int pos);
    return (pos > 0) && ((pos & (pos - 1)) == 0);
  endfunction

  // Data index carried by a non-power-of-two Hamming position (1-based).
  function automatic int pos_to_data_idx(input int pos);
    int idx;
    idx = 0;
    for (int i = 1; i < pos; i++) begin
      if (!is_pow2(i)) idx++;
    end
    return idx;
  endfunction

endpackage

// File: rtl/secded_syndrome.sv
// Combinational Hamming syndrome and overall parity of an N-bit SECDED codeword.
module secded_syndrome
  import secded_pkg::*;
#(
  parameter int N = 13,
  parameter int P = 4
) (
  input  logic [N-1:0] code,
  output logic [P-1:0] s,
  output logic         q
);

  // Bit j of the syndrome covers every Hamming position whose index has bit j set.
  function automatic logic [N-1:0] pos_mask(input int j);
    logic [N-1:0] m;
    m = '0;
    for (int i = 0; i < N - 1; i++) begin
      m[i] = (((i + 1) >> j) % 2) == 1;
    end
    return m;
  endfunction

  for (genvar gi = 0; gi < P; gi++) begin : g_syn
    localparam logic [N-1:0] MASK = pos_mask(gi);
    assign s[gi] = ^(code & MASK);
  end

  assign q = ^code;

endmodule

// File: rtl/secded_decoder_pipe.sv
// Two-stage pipelined SECDED decoder with valid/ready on both sides.
// Define SECDED_CNT_EN to build the saturating corrected/uncorrectable error counters.
module secded_decoder_pipe
  import secded_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16,
  localparam int P = calc_p(DATA_W),
  localparam int N = DATA_W + P + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N-1:0]      code_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              err_single,
  output logic              err_double,
  output logic [P-1:0]      syndrome,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  uncorr_cnt
);

  logic              s1_valid_reg;
  logic [N-1:0]      s1_code_reg;
  logic [P-1:0]      s1_syn_reg;
  logic              s1_par_reg;
  logic [P-1:0]      syn_next;
  logic              par_next;
  logic              adv1;
  logic              adv2;

  logic              out_valid_reg;
  logic [DATA_W-1:0] data_reg;
  logic              single_reg;
  logic              double_reg;
  logic [P-1:0]      syn_reg;

  logic [N-1:0]      flip_mask;
  logic [N-1:0]      corr_code;
  logic [DATA_W-1:0] data_next;
  status_e           status_next;
  logic              layout_bits_unused;

  secded_syndrome #(.N(N), .P(P)) u_syn (
    .code (code_in),
    .s    (syn_next),
    .q    (par_next)
  );

  assign adv2     = !out_valid_reg || out_ready;
  assign adv1     = !s1_valid_reg || adv2;
  assign in_ready = adv1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_code_reg  <= '0;
      s1_syn_reg   <= '0;
      s1_par_reg   <= 1'b0;
    end else if (adv1) begin
      s1_valid_reg <= in_valid;
      if (in_valid) begin
        s1_code_reg <= code_in;
        s1_syn_reg  <= syn_next;
        s1_par_reg  <= par_next;
      end
    end
  end

  // Only a single error at a real position (q=1, 1<=s<=N-1) gets flipped.
  always_comb begin
    flip_mask = '0;
    for (int i = 0; i < N - 1; i++) begin
      if (s1_syn_reg == P'(i + 1)) flip_mask[i] = s1_par_reg;
    end
  end

  always_comb begin
    if (s1_syn_reg == '0) begin
      status_next = s1_par_reg ? SINGLE : CLEAN;
    end else if (s1_par_reg && (32'(s1_syn_reg) <= N - 1)) begin
      status_next = SINGLE;
    end else begin
      status_next = DOUBLE;
    end
  end

  assign corr_code          = s1_code_reg ^ flip_mask;
  assign layout_bits_unused = ^corr_code;

  for (genvar gi = 1; gi < N; gi++) begin : g_data
    if (!is_pow2(gi)) begin : g_bit
      assign data_next[pos_to_data_idx(gi)] = corr_code[gi-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      data_reg      <= '0;
      single_reg    <= 1'b0;
      double_reg    <= 1'b0;
      syn_reg       <= '0;
    end else if (adv2) begin
      out_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        data_reg   <= data_next;
        single_reg <= (status_next == SINGLE);
        double_reg <= (status_next == DOUBLE);
        syn_reg    <= s1_syn_reg;
      end
    end
  end

  assign out_valid  = out_valid_reg;
  assign data_out   = data_reg;
  assign err_single = single_reg;
  assign err_double = double_reg;
  assign syndrome   = syn_reg;

`ifdef SECDED_CNT_EN
  logic             load2;
  logic [CNT_W-1:0] corr_cnt_reg;
  logic [CNT_W-1:0] uncorr_cnt_reg;

  assign load2 = adv2 && s1_valid_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      corr_cnt_reg   <= '0;
      uncorr_cnt_reg <= '0;
    end else if (cnt_clr) begin
      corr_cnt_reg   <= '0;
      uncorr_cnt_reg <= '0;
    end else if (load2) begin
      if (status_next == SINGLE && corr_cnt_reg != '1) corr_cnt_reg <= corr_cnt_reg + CNT_W'(1);
      if (status_next == DOUBLE && uncorr_cnt_reg != '1) uncorr_cnt_reg <= uncorr_cnt_reg + CNT_W'(1);
    end
  end

  assign corr_cnt   = corr_cnt_reg;
  assign uncorr_cnt = uncorr_cnt_reg;
`else
  logic cnt_clr_unused;
  assign cnt_clr_unused = cnt_clr;
  assign corr_cnt       = '0;
  assign uncorr_cnt     = '0;
`endif

endmodule

// File: tb/tb_secded_decoder_pipe.sv
// Directed + randomized bench for secded_decoder_pipe (DATA_W=8, CNT_W=2) against an encode/inject reference model.
module tb_secded_decoder_pipe;

`ifdef SECDED_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif
  localparam int CNT_MAX = 3;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [12:0] code_in;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  data_out;
  logic        err_single;
  logic        err_double;
  logic [3:0]  syndrome;
  logic        cnt_clr;
  logic [1:0]  corr_cnt;
  logic [1:0]  uncorr_cnt;

  secded_decoder_pipe #(.DATA_W(8), .CNT_W(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .code_in    (code_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .data_out   (data_out),
    .err_single (err_single),
    .err_double (err_double),
    .syndrome   (syndrome),
    .cnt_clr    (cnt_clr),
    .corr_cnt   (corr_cnt),
    .uncorr_cnt (uncorr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       single;
    logic       dbl;
    logic [3:0] syn;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   tests = 0;
  int   fails = 0;
  int   m_corr = 0;
  int   m_uncorr = 0;
  bit   accepted;
  bit   popped;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference encoder: data bits fill non-power-of-two positions; check bits cancel their XOR of positions.
  function automatic logic [12:0] enc(input logic [7:0] d);
    logic [12:0] c;
    int k;
    int x;
    c = '0;
    k = 0;
    x = 0;
    for (int pos = 1; pos <= 12; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        c[pos-1] = d[k];
        if (d[k]) x = x ^ pos;
        k++;
      end
    end
    for (int j = 0; j < 4; j++) c[(1 << j) - 1] = x[j];
    c[12] = ^c[11:0];
    return c;
  endfunction

  function automatic logic [7:0] extract(input logic [12:0] c);
    logic [7:0] d;
    int k;
    d = '0;
    k = 0;
    for (int pos = 1; pos <= 12; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        d[k] = c[pos-1];
        k++;
      end
    end
    return d;
  endfunction

  // Build a codeword with nf flipped bits (code bit indices b0..b2) and the result the decoder owes for it.
  task automatic prep(input logic [7:0] d, input int nf, input int b0, input int b1, input int b2);
    logic [12:0] c;
    int bits[3];
    int syn;
    c = enc(d);
    bits[0] = b0;
    bits[1] = b1;
    bits[2] = b2;
    syn = 0;
    for (int i = 0; i < nf; i++) begin
      c[bits[i]] = ~c[bits[i]];
      syn = syn ^ ((bits[i] == 12) ? 0 : bits[i] + 1);
    end
    code_in    = c;
    cur.syn    = 4'(syn);
    cur.single = (nf == 1);
    cur.dbl    = (nf >= 2);
    cur.data   = (nf <= 1) ? d : extract(c);
  endtask

  task automatic prep_random();
    int nf;
    int a;
    int b;
    nf = $urandom_range(2);
    a  = $urandom_range(12);
    b  = (a + 1 + $urandom_range(11)) % 13;
    prep(8'($urandom), nf, a, b, 0);
  endtask

  task automatic tick();
    exp_t e;
    @(negedge clk);
    popped   = 1'b0;
    accepted = 1'b0;
    if (out_valid && out_ready) begin
      popped = 1'b1;
      chk("out_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("data_out", 32'(data_out), 32'(e.data));
        chk("err_single", 32'(err_single), 32'(e.single));
        chk("err_double", 32'(err_double), 32'(e.dbl));
        chk("syndrome", 32'(syndrome), 32'(e.syn));
      end
    end
    if (in_valid && in_ready) begin
      accepted = 1'b1;
      exp_q.push_back(cur);
      if (cur.single && m_corr < CNT_MAX) m_corr++;
      if (cur.dbl && m_uncorr < CNT_MAX) m_uncorr++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_counters(input string tag);
    chk({tag, "_corr_cnt"}, 32'(corr_cnt), CNT_ON ? 32'(m_corr) : 0);
    chk({tag, "_uncorr_cnt"}, 32'(uncorr_cnt), CNT_ON ? 32'(m_uncorr) : 0);
  endtask

  task automatic send_one(input logic [7:0] d, input int nf, input int b0, input int b1, input int b2);
    int lat;
    prep(d, nf, b0, b1, b2);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("accept", 32'(accepted), 1);
    in_valid = 1'b0;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!popped && lat < 10);
    chk("latency", lat, 2);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    int nacc;
    int pops;
    int sent;
    logic [7:0] words[4];

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cnt_clr   = 1'b0;
    code_in   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_data_out", 32'(data_out), 0);
    chk("rst_err_single", 32'(err_single), 0);
    chk("rst_err_double", 32'(err_double), 0);
    chk("rst_syndrome", 32'(syndrome), 0);
    check_counters("rst");
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 1);

    // Plan vectors: clean, single at position 5, overall parity bit, double at bits 0/1.
    send_one(8'hA5, 0, 0, 0, 0);
    check_counters("clean");
    send_one(8'hA5, 1, 4, 0, 0);
    check_counters("single_pos5");
    send_one(8'hA5, 1, 12, 0, 0);
    check_counters("single_parity");
    send_one(8'hA5, 2, 0, 1, 0);
    check_counters("double_b0b1");
    // Odd parity with syndrome 15 (positions 1,2,12): beyond the codeword, uncorrectable.
    send_one(8'hA5, 3, 0, 1, 11);
    check_counters("invalid_pos");

    // Back-pressure: 4 clean words with the consumer stalled.
    words[0] = 8'h11;
    words[1] = 8'h22;
    words[2] = 8'h33;
    words[3] = 8'h44;
    nacc = 0;
    pops = 0;
    out_ready = 1'b0;
    prep(words[0], 0, 0, 0, 0);
    in_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (accepted) begin
        nacc++;
        if (nacc < 4) prep(words[nacc], 0, 0, 0, 0);
        else in_valid = 1'b0;
      end
      if (c >= 1) begin
        chk("stall_in_ready", 32'(in_ready), 0);
        chk("stall_accepted", nacc, 2);
        chk("stall_out_valid", 32'(out_valid), 1);
        chk("stall_data_stable", 32'(data_out), 32'(words[0]));
      end
    end
    out_ready = 1'b1;
    for (int c = 0; c < 30 && (nacc < 4 || exp_q.size() != 0); c++) begin
      tick();
      if (popped) pops++;
      if (accepted) begin
        nacc++;
        if (nacc < 4) prep(words[nacc], 0, 0, 0, 0);
        else in_valid = 1'b0;
      end
    end
    chk("stall_pops", pops, 4);
    chk("stall_accepts", nacc, 4);

    // Saturation of the corrected counter.
    for (int i = 0; i < 5; i++) send_one(8'($urandom), 1, $urandom_range(12), 0, 0);
    check_counters("saturate");

    // Clear coincides with the stage-2 load of a sixth single-error word.
    prep(8'h5A, 1, 6, 0, 0);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("clr_accept", 32'(accepted), 1);
    in_valid = 1'b0;
    cnt_clr  = 1'b1;
    tick();
    cnt_clr  = 1'b0;
    m_corr   = 0;
    m_uncorr = 0;
    drain();
    check_counters("clear");

    // Randomized traffic with random back-pressure on both sides.
    sent = 0;
    prep_random();
    for (int cyc = 0; cyc < 3000 && sent < 300; cyc++) begin
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(3) != 0);
      tick();
      if (accepted) begin
        sent++;
        prep_random();
      end
    end
    chk("random_sent", sent, 300);
    drain();
    check_counters("random");

    // Asynchronous reset in the middle of a stream.
    in_valid  = 1'b1;
    out_ready = 1'b1;
    prep_random();
    for (int i = 0; i < 3; i++) begin
      tick();
      if (accepted) prep_random();
    end
    chk("pre_reset_out_valid", 32'(out_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_in_ready", 32'(in_ready), 1);
    chk("midrst_data_out", 32'(data_out), 0);
    exp_q.delete();
    m_corr   = 0;
    m_uncorr = 0;
    check_counters("midrst");
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("post_reset_idle", 32'(out_valid), 0);
    send_one(8'h3C, 1, 9, 0, 0);
    send_one(8'hC3, 2, 2, 12, 0);
    check_counters("post_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/secded_decoder_pipe.md
Name: secded_decoder_pipe

Overview:
- Parametrised, pipelined Hamming SECDED decoder; counterpart to the team's SECDED encoders, generalised from the fixed 8-bit data case to any DATA_W.
- Sits on the UART RX path after frame assembly and before the RX FIFO.
- Accepts one codeword per valid/ready handshake and returns corrected data with an error status.
- Optionally keeps saturating error counters.

Parameters:
- DATA_W, 8, data bits per codeword; legal range 4..32.
- CNT_W, 16, width of each error counter.
- Derived localparam P: smallest integer with 2^P >= DATA_W+P+1 (P=4 for DATA_W=8).
- Derived localparam N = DATA_W+P+1, the codeword width (13 for DATA_W=8).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  codeword present.
- in_ready  out  1  decoder can accept.
- code_in  in  N  codeword; bit i = Hamming position i+1 for i<N-1; bit N-1 = overall even parity.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- data_out  out  DATA_W  corrected data; data bit k = k-th non-power-of-two position, ascending.
- err_single  out  1  single error detected and corrected.
- err_double  out  1  uncorrectable error detected.
- syndrome  out  P  Hamming syndrome of the codeword.
- cnt_clr  in  1  synchronous clear of the counters.
- corr_cnt  out  CNT_W  corrected-error count.
- uncorr_cnt  out  CNT_W  uncorrectable-error count.

Behaviour:
- Reset: all pipeline valids=0; out_valid=0; data_out=0; err_single=0; err_double=0; syndrome=0; counters=0.
  - in_ready=1 once reset deasserts.
  - Reset mid-operation discards every in-flight word.
- Pipeline:
  - Stage 1 registers code_in, the syndrome s (XOR of all positions whose index has bit j set, j=0..P-1) and the overall parity q (XOR of all N bits).
  - Stage 2 classifies, corrects and registers the outputs.
- Latency: 2 cycles from the in_valid&&in_ready edge to out_valid, when not stalled. Throughput is 1 word/cycle.
- Handshake:
  - Stage 2 advances when !out_valid || out_ready.
  - Stage 1 advances when stage 1 is empty or stage 2 advances.
  - in_ready is that stage-1 advance condition.
  - Outputs stay stable while out_valid && !out_ready.
  - No bubble is inserted when both sides stream.
- Classification:
  - s==0, q==0: clean. Both error flags are 0.
  - q==1, s==0: the overall parity bit is in error. Data is unchanged; err_single=1.
  - q==1, 1<=s<=N-1: flip position s, then extract data; err_single=1.
  - q==1, s>N-1: invalid position. err_double=1; data is extracted uncorrected.
  - q==0, s!=0: double error. err_double=1; data is extracted uncorrected.
- err_single and err_double are never both 1.
- Counters:
  - Each counter increments once per word, at the stage-2 load of a flagged result.
  - Counters saturate at all-ones.
  - cnt_clr has priority over an increment in the same cycle.

Optional Feature:
- Macro SECDED_CNT_EN.
- Defined: corr_cnt, uncorr_cnt and the cnt_clr logic are present as described under Behaviour.
- Undefined: no counter registers are built; corr_cnt and uncorr_cnt are tied to 0; cnt_clr is ignored.
- Decode behaviour is identical in both cases.

Decomposition:
- Package secded_pkg holds:
  - A function computing P from DATA_W.
  - Position-to-data-index and is-power-of-two helper functions.
  - Status encoding constants: CLEAN, SINGLE, DOUBLE.
- The encoder and decoder both use secded_pkg, so the bit layout is defined once.
- One natural sub-module: secded_syndrome (combinational; code_in -> s, q), instantiated in stage 1.
- Counter logic stays inline.

Test Plan:
- DATA_W=8, code_in=0x0A27, out_ready=1 -> 2 cycles later: data_out=0xA5, syndrome=0, both flags 0.
- code_in=0x0A37 (bit4 flipped, position 5) -> data_out=0xA5, syndrome=5, err_single=1, corr_cnt=1.
- code_in=0x1A27 (overall parity bit flipped) -> data_out=0xA5, syndrome=0, err_single=1.
- code_in=0x0A24 (bits 0 and 1 flipped) -> syndrome=3, err_double=1, uncorr_cnt=1.
- Stream 4 clean words with out_ready held 0 for 3 cycles, then released:
  - in_ready drops after 2 words are accepted.
  - Outputs stay stable while stalled.
  - All 4 words emerge in order with no loss or duplication.
- CNT_W=2, SECDED_CNT_EN defined, 5 single-error words -> corr_cnt saturates at 3.
  - Then cnt_clr=1 in the same cycle as a 6th single-error word -> corr_cnt=0.
  - Reset asserted mid-stream -> out_valid=0 immediately.
